// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard bus: pipeline stage status into the hazard controller,
// forwarding/stall/flush controls back out to the pipe registers.
interface hazard_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_SRC*5-1:0]      src_reg_d;
    logic [NUM_SRC-1:0]        src_used_d;
    logic                      md_start_d;
    logic                      md_use_d;
    logic                      reg_write_e;
    logic                      reg_write_m;
    logic                      reg_write_w;
    logic [4:0]                write_reg_e;
    logic [4:0]                write_reg_m;
    logic [4:0]                write_reg_w;
    logic                      mem_to_reg_e;
    logic                      mem_to_reg_m;
    logic [DATA_W-1:0]         alu_out_e;
    logic [DATA_W-1:0]         alu_out_m;
    logic [DATA_W-1:0]         result_w;
    logic                      branch_taken_e;
    logic [NUM_SRC-1:0]        fwd_en;
    logic [NUM_SRC*DATA_W-1:0] fwd_data;
    logic                      stall_f;
    logic                      stall_d;
    logic                      flush_d;
    logic                      flush_e;
    logic                      md_busy;
    logic [31:0]               perf_stalls;
    logic [31:0]               perf_flushes;

    modport master (
        output src_reg_d, src_used_d, md_start_d, md_use_d,
        output reg_write_e, reg_write_m, reg_write_w,
        output write_reg_e, write_reg_m, write_reg_w,
        output mem_to_reg_e, mem_to_reg_m,
        output alu_out_e, alu_out_m, result_w, branch_taken_e,
        input  fwd_en, fwd_data, stall_f, stall_d, flush_d, flush_e,
        input  md_busy, perf_stalls, perf_flushes
    );

    modport slave (
        input  src_reg_d, src_used_d, md_start_d, md_use_d,
        input  reg_write_e, reg_write_m, reg_write_w,
        input  write_reg_e, write_reg_m, write_reg_w,
        input  mem_to_reg_e, mem_to_reg_m,
        input  alu_out_e, alu_out_m, result_w, branch_taken_e,
        output fwd_en, fwd_data, stall_f, stall_d, flush_d, flush_e,
        output md_busy, perf_stalls, perf_flushes
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: E>M>W forwarding, load-use and mult/div stalls,
// redirect flush. Define HAZARD_PERF_EN to build the stall/redirect perf counters.
module hazard_ctrl #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_W     = 32,
    parameter int MD_LATENCY = 4
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);
    logic [NUM_SRC-1:0]        fwd_en_c;
    logic [NUM_SRC*DATA_W-1:0] fwd_data_c;
    logic [NUM_SRC-1:0]        ld_hit;
    logic                      load_stall;
    logic                      md_stall;
    logic                      stall;
    logic                      md_accept;
    logic [4:0]                md_cnt;

    function automatic logic reg_match(input logic wr, input logic [4:0] dst,
                                       input logic [4:0] src);
        return wr && (dst == src);
    endfunction

    // The youngest matching stage always decides; a load there blocks older forwards.
    always_comb begin
        fwd_en_c   = '0;
        fwd_data_c = '0;
        ld_hit     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hz.src_used_d[i] && (hz.src_reg_d[5*i +: 5] != 5'd0)) begin
                if (reg_match(hz.reg_write_e, hz.write_reg_e, hz.src_reg_d[5*i +: 5])) begin
                    if (hz.mem_to_reg_e) begin
                        ld_hit[i] = 1'b1;
                    end else begin
                        fwd_en_c[i]                      = 1'b1;
                        fwd_data_c[DATA_W*i +: DATA_W]   = hz.alu_out_e;
                    end
                end else if (reg_match(hz.reg_write_m, hz.write_reg_m, hz.src_reg_d[5*i +: 5])) begin
                    if (hz.mem_to_reg_m) begin
                        ld_hit[i] = 1'b1;
                    end else begin
                        fwd_en_c[i]                      = 1'b1;
                        fwd_data_c[DATA_W*i +: DATA_W]   = hz.alu_out_m;
                    end
                end else if (reg_match(hz.reg_write_w, hz.write_reg_w, hz.src_reg_d[5*i +: 5])) begin
                    fwd_en_c[i]                      = 1'b1;
                    fwd_data_c[DATA_W*i +: DATA_W]   = hz.result_w;
                end
            end
        end
    end

    assign load_stall = |ld_hit;
    assign md_stall   = hz.md_use_d && (md_cnt != 5'd0);
    assign stall      = load_stall || md_stall;

    // A redirect discards the D instruction, so it overrides any stall.
    assign hz.fwd_en   = fwd_en_c;
    assign hz.fwd_data = fwd_data_c;
    assign hz.stall_f  = stall && !hz.branch_taken_e;
    assign hz.stall_d  = stall && !hz.branch_taken_e;
    assign hz.flush_e  = stall && !hz.branch_taken_e;
    assign hz.flush_d  = hz.branch_taken_e;
    assign hz.md_busy  = (md_cnt != 5'd0);

    assign md_accept = hz.md_start_d && !stall && !hz.branch_taken_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt <= 5'd0;
        end else if (md_accept) begin
            md_cnt <= 5'(MD_LATENCY);
        end else if (md_cnt != 5'd0) begin
            md_cnt <= md_cnt - 5'd1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stalls_q;
    logic [31:0] perf_flushes_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stalls_q  <= 32'd0;
            perf_flushes_q <= 32'd0;
        end else begin
            if (stall && !hz.branch_taken_e) perf_stalls_q <= perf_stalls_q + 32'd1;
            if (hz.branch_taken_e)          perf_flushes_q <= perf_flushes_q + 32'd1;
        end
    end

    assign hz.perf_stalls  = perf_stalls_q;
    assign hz.perf_flushes = perf_flushes_q;
`else
    assign hz.perf_stalls  = 32'd0;
    assign hz.perf_flushes = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding priority, r0, load-use, mult/div,
// redirect override and reset, with hand-computed expectations.
module tb_hazard_ctrl;
    localparam int NUM_SRC = 2;
    localparam int DATA_W  = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_stalls;
    int   exp_flushes;

    hazard_ctrl_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) hz ();

    hazard_ctrl #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .MD_LATENCY(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.src_reg_d      = '0;
        hz.src_used_d     = '0;
        hz.md_start_d     = 1'b0;
        hz.md_use_d       = 1'b0;
        hz.reg_write_e    = 1'b0;
        hz.reg_write_m    = 1'b0;
        hz.reg_write_w    = 1'b0;
        hz.write_reg_e    = 5'd0;
        hz.write_reg_m    = 5'd0;
        hz.write_reg_w    = 5'd0;
        hz.mem_to_reg_e   = 1'b0;
        hz.mem_to_reg_m   = 1'b0;
        hz.alu_out_e      = '0;
        hz.alu_out_m      = '0;
        hz.result_w       = '0;
        hz.branch_taken_e = 1'b0;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_stall_f"}, 64'(hz.stall_f), 64'(exp));
        chk({tag, "_stall_d"}, 64'(hz.stall_d), 64'(exp));
        chk({tag, "_flush_e"}, 64'(hz.flush_e), 64'(exp));
    endtask

    task automatic chk_perf(input string tag);
`ifdef HAZARD_PERF_EN
        chk({tag, "_perf_stalls"},  64'(hz.perf_stalls),  64'(exp_stalls));
        chk({tag, "_perf_flushes"}, 64'(hz.perf_flushes), 64'(exp_flushes));
`else
        chk({tag, "_perf_stalls"},  64'(hz.perf_stalls),  64'd0);
        chk({tag, "_perf_flushes"}, 64'(hz.perf_flushes), 64'd0);
`endif
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_stalls  = 0;
        exp_flushes = 0;
        rst = 1'b1;
        clear_inputs();
        step();
        step();

        // Reset state with all inputs zero
        chk("rst_fwd_en",   64'(hz.fwd_en),   64'd0);
        chk("rst_fwd_data", 64'(hz.fwd_data), 64'd0);
        chk_stall("rst", 1'b0);
        chk("rst_flush_d",  64'(hz.flush_d),  64'd0);
        chk("rst_md_busy",  64'(hz.md_busy),  64'd0);
        chk_perf("rst");
        rst = 1'b0;

        // 1: forwarding priority E > M > W on r5
        step();
        hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd5; hz.alu_out_e = 32'hAAAA0001;
        hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd5; hz.alu_out_m = 32'hAAAA0002;
        hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd5; hz.result_w  = 32'hAAAA0003;
        hz.src_reg_d = {5'd0, 5'd5}; hz.src_used_d = 2'b01;
        #1;
        chk("fwd_e_en",   64'(hz.fwd_en),   64'h1);
        chk("fwd_e_data", 64'(hz.fwd_data), 64'h00000000_AAAA0001);
        chk_stall("fwd_e", 1'b0);
        hz.reg_write_e = 1'b0;
        #1;
        chk("fwd_m_data", 64'(hz.fwd_data), 64'h00000000_AAAA0002);
        hz.reg_write_m = 1'b0;
        #1;
        chk("fwd_w_data", 64'(hz.fwd_data), 64'h00000000_AAAA0003);
        hz.src_reg_d = {5'd5, 5'd5}; hz.src_used_d = 2'b10;
        #1;
        chk("fwd_op1_en",   64'(hz.fwd_en),   64'h2);
        chk("fwd_op1_data", 64'(hz.fwd_data), 64'hAAAA0003_00000000);

        // 2: r0 never forwards or stalls
        step();
        hz.reg_write_e = 1'b1; hz.reg_write_m = 1'b1; hz.reg_write_w = 1'b1;
        hz.write_reg_e = 5'd0; hz.write_reg_m = 5'd0; hz.write_reg_w = 5'd0;
        hz.mem_to_reg_e = 1'b1;
        hz.src_reg_d = {5'd0, 5'd0}; hz.src_used_d = 2'b11;
        #1;
        chk("r0_fwd_en",   64'(hz.fwd_en),   64'd0);
        chk("r0_fwd_data", 64'(hz.fwd_data), 64'd0);
        chk_stall("r0", 1'b0);

        // 3: load-use, lw r3 in E then M, then W forwards
        step();
        clear_inputs();
        hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd3; hz.mem_to_reg_e = 1'b1;
        hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd3; hz.alu_out_m = 32'h11111111;
        hz.src_reg_d = {5'd0, 5'd3}; hz.src_used_d = 2'b01;
        #1;
        chk_stall("ld_e", 1'b1);
        chk("ld_e_flush_d", 64'(hz.flush_d), 64'd0);
        chk("ld_e_fwd_en",  64'(hz.fwd_en),  64'd0);
        exp_stalls++;
        step();
        hz.reg_write_e = 1'b0; hz.mem_to_reg_e = 1'b0;
        hz.reg_write_m = 1'b1; hz.write_reg_m = 5'd3; hz.mem_to_reg_m = 1'b1;
        #1;
        chk_stall("ld_m", 1'b1);
        chk("ld_m_fwd_en", 64'(hz.fwd_en), 64'd0);
        exp_stalls++;
        step();
        hz.reg_write_m = 1'b0; hz.mem_to_reg_m = 1'b0;
        hz.reg_write_w = 1'b1; hz.write_reg_w = 5'd3; hz.result_w = 32'hDEADBEEF;
        #1;
        chk_stall("ld_w", 1'b0);
        chk("ld_w_fwd_en",   64'(hz.fwd_en),   64'h1);
        chk("ld_w_fwd_data", 64'(hz.fwd_data), 64'h00000000_DEADBEEF);
        chk_perf("ld");

        // 4: mult/div busy window, dependent vs unrelated instruction
        step();
        clear_inputs();
        hz.md_start_d = 1'b1; hz.md_use_d = 1'b1;
        #1;
        chk("md_start_busy", 64'(hz.md_busy), 64'd0);
        chk_stall("md_start", 1'b0);
        step();
        hz.md_start_d = 1'b0; hz.md_use_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("md_busy_%0d", k), 64'(hz.md_busy), 64'd1);
            chk_stall($sformatf("md_use_%0d", k), 1'b1);
            exp_stalls++;
            step();
        end
        #1;
        chk("md_done_busy", 64'(hz.md_busy), 64'd0);
        chk_stall("md_done", 1'b0);
        hz.md_start_d = 1'b1;
        step();
        hz.md_start_d = 1'b0; hz.md_use_d = 1'b0;
        hz.src_reg_d = {5'd0, 5'd7}; hz.src_used_d = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("md_unrel_busy_%0d", k), 64'(hz.md_busy), 64'd1);
            chk_stall($sformatf("md_unrel_%0d", k), 1'b0);
            step();
        end
        #1;
        chk("md_unrel_idle", 64'(hz.md_busy), 64'd0);

        // 5: redirect overrides a load stall and blocks a mult/div start
        clear_inputs();
        hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd9; hz.mem_to_reg_e = 1'b1;
        hz.src_reg_d = {5'd0, 5'd9}; hz.src_used_d = 2'b01;
        hz.md_start_d = 1'b1; hz.md_use_d = 1'b1; hz.branch_taken_e = 1'b1;
        #1;
        chk("br_flush_d", 64'(hz.flush_d), 64'd1);
        chk_stall("br", 1'b0);
        exp_flushes++;
        step();
        hz.branch_taken_e = 1'b0;
        #1;
        chk("br_md_busy", 64'(hz.md_busy), 64'd0);
        chk_stall("ld_nobr", 1'b1);
        step();
        #1;
        chk("ld_md_blocked", 64'(hz.md_busy), 64'd0);
        exp_stalls++;
        chk_perf("pre_rst");

        // 6: reset during the second busy cycle of a mult/div
        clear_inputs();
        hz.md_start_d = 1'b1;
        step();
        hz.md_start_d = 1'b0;
        #1;
        chk("rst_md_c1", 64'(hz.md_busy), 64'd1);
        step();
        chk("rst_md_c2", 64'(hz.md_busy), 64'd1);
        rst = 1'b1;
        step();
        chk("rst_md_drop", 64'(hz.md_busy), 64'd0);
        exp_stalls  = 0;
        exp_flushes = 0;
        chk_perf("mid_rst");
        hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd4; hz.mem_to_reg_e = 1'b1;
        hz.src_reg_d = {5'd4, 5'd0}; hz.src_used_d = 2'b10;
        #1;
        chk_stall("rst_ld", 1'b1);
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
